// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM states and special-case constants for the EX multiply/divide unit
package muldiv_pkg;

  // funct3 encodings of the RV32M instructions
  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // RISC-V mandated results for divide by zero and signed overflow
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

  // rs1 is treated as two's complement for these ops
  function automatic logic signed_a(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as two's complement for these ops (MULHSU keeps rs2 unsigned)
  function automatic logic signed_b(input logic [2:0] op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// rtl/ex_muldiv_unit_if.sv - EX-stage request/response bundle between the pipeline and the multiply/divide unit
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] opa;
  logic [XLEN-1:0] opb;
  logic            flush;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;

  // pipeline side: issues the instruction and consumes stall/result
  modport master (
    output start, op, opa, opb, flush,
    input  stall, done, result
  );

  // unit side
  modport slave (
    input  start, op, opa, opb, flush,
    output stall, done, result
  );
endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one combinational radix-2 step shared by shift-add multiply and restoring divide
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic            div_mode,
  input  logic [XLEN-1:0] hi_in,
  input  logic [XLEN-1:0] lo_in,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] hi_out,
  output logic [XLEN-1:0] lo_out
);

  logic [XLEN:0] add_sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // multiply: add multiplicand when the low multiplier bit is set, then shift the 64-bit pair right;
  // divide: shift the next dividend bit into the partial remainder and keep the trial subtract if it does not borrow
  always_comb begin
    add_sum = {1'b0, hi_in} + (lo_in[0] ? {1'b0, b} : '0);
    shifted = {hi_in, lo_in[XLEN-1]};
    diff    = shifted - {1'b0, b};
    if (div_mode) begin
      if (diff[XLEN]) begin
        hi_out = shifted[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b0};
      end else begin
        hi_out = diff[XLEN-1:0];
        lo_out = {lo_in[XLEN-2:0], 1'b1};
      end
    end else begin
      hi_out = add_sum[XLEN:1];
      lo_out = {add_sum[0], lo_in[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit for the EX stage; MULDIV_FAST_MUL_EN selects a single-cycle multiplier
module ex_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst,
  ex_muldiv_unit_if.slave   bus
);

  localparam int N  = XLEN / ITER_PER_CYCLE;
  localparam int CW = $clog2(N + 1);

  state_t          state, state_nx;
  logic [CW-1:0]   count;
  logic [2:0]      op_q;
  logic            neg_res, neg_rem;
  logic [XLEN-1:0] acc_hi, acc_lo, b_q, result_q;
  logic            stall_c, done_c;

  // operand decode at the start edge
  logic            sa, sb, accept, div_zero, div_ovf, fast_mul, fast;
  logic [XLEN-1:0] mag_a, mag_b, fast_word, fast_mul_word;

  assign accept   = (state == ST_IDLE) && bus.start && !bus.flush;
  assign sa       = signed_a(bus.op) & bus.opa[XLEN-1];
  assign sb       = signed_b(bus.op) & bus.opb[XLEN-1];
  assign mag_a    = sa ? -bus.opa : bus.opa;
  assign mag_b    = sb ? -bus.opb : bus.opb;
  assign div_zero = is_div(bus.op) && (bus.opb == '0);
  assign div_ovf  = is_div(bus.op) && !bus.op[0] && (bus.opa == INT_MIN) && (bus.opb == {XLEN{1'b1}});

`ifdef MULDIV_FAST_MUL_EN
  // 33x33 signed product: each operand carries one extra sign bit chosen by the op's signedness
  logic signed [2*XLEN-1:0] fm_a, fm_b, fm_p;
  assign fm_a          = {{XLEN{signed_a(bus.op) & bus.opa[XLEN-1]}}, bus.opa};
  assign fm_b          = {{XLEN{signed_b(bus.op) & bus.opb[XLEN-1]}}, bus.opb};
  assign fm_p          = fm_a * fm_b;
  assign fast_mul      = !is_div(bus.op);
  assign fast_mul_word = (bus.op == OP_MUL) ? fm_p[XLEN-1:0] : fm_p[2*XLEN-1:XLEN];
`else
  assign fast_mul      = 1'b0;
  assign fast_mul_word = '0;
`endif

  assign fast = div_zero || div_ovf || fast_mul;

  // result for the ops that skip RUN; op[1] separates REM* from DIV*
  always_comb begin
    fast_word = fast_mul_word;
    if (div_zero) begin
      fast_word = bus.op[1] ? bus.opa : DIV_ZERO_Q;
    end else if (div_ovf) begin
      fast_word = bus.op[1] ? '0 : INT_MIN;
    end
  end

  // iterative datapath: ITER_PER_CYCLE radix-2 steps chained per clock
  logic            div_q;
  logic [XLEN-1:0] ch_hi [0:ITER_PER_CYCLE];
  logic [XLEN-1:0] ch_lo [0:ITER_PER_CYCLE];

  assign div_q    = is_div(op_q);
  assign ch_hi[0] = acc_hi;
  assign ch_lo[0] = acc_lo;

  for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
    mdu_step #(.XLEN(XLEN)) u_step (
      .div_mode (div_q),
      .hi_in    (ch_hi[g]),
      .lo_in    (ch_lo[g]),
      .b        (b_q),
      .hi_out   (ch_hi[g+1]),
      .lo_out   (ch_lo[g+1])
    );
  end

  // sign fix-up of the final step's output, applied as RUN hands over to DONE
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, run_word;

  assign prod   = {ch_hi[ITER_PER_CYCLE], ch_lo[ITER_PER_CYCLE]};
  assign prod_s = neg_res ? -prod : prod;
  assign quo_s  = neg_res ? -ch_lo[ITER_PER_CYCLE] : ch_lo[ITER_PER_CYCLE];
  assign rem_s  = neg_rem ? -ch_hi[ITER_PER_CYCLE] : ch_hi[ITER_PER_CYCLE];

  // pick the architectural word for the latched op
  always_comb begin
    run_word = rem_s;
    case (op_q)
      OP_MUL:                      run_word = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: run_word = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:             run_word = quo_s;
      OP_REM, OP_REMU:             run_word = rem_s;
      default:                     run_word = rem_s;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // next state, stall and done; stall is combinational so the first EX cycle already freezes the pipe
  always_comb begin
    state_nx = state;
    stall_c  = 1'b0;
    done_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          stall_c  = 1'b1;
          state_nx = fast ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        stall_c = 1'b1;
        if (bus.flush)              state_nx = ST_IDLE;
        else if (count == CW'(1))   state_nx = ST_DONE;
      end
      ST_DONE: begin
        done_c   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // operand capture, iteration and result write-back; a flush leaves result untouched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      op_q     <= '0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q    <= bus.op;
      neg_res <= sa ^ sb;
      neg_rem <= sa;
      acc_hi  <= '0;
      acc_lo  <= mag_a;
      b_q     <= mag_b;
      count   <= CW'(N);
      if (fast) result_q <= fast_word;
    end else if ((state == ST_RUN) && !bus.flush) begin
      acc_hi <= ch_hi[ITER_PER_CYCLE];
      acc_lo <= ch_lo[ITER_PER_CYCLE];
      count  <= count - 1'b1;
      if (count == CW'(1)) result_q <= run_word;
    end
  end

  assign bus.stall  = stall_c;
  assign bus.done   = done_c;
  assign bus.result = result_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb/tb_ex_muldiv_unit.sv - randomized and directed bench for ex_muldiv_unit against an arithmetic reference model
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef MULDIV_FAST_MUL_EN
  localparam int LAT_MUL = 1;
`else
  localparam int LAT_MUL = 33;
`endif

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, want, $time);
    end
  endtask

  // architectural result of an RV32M op, straight from the ISA definition
  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] a64, b64;
    logic [63:0]        p;
    a64 = {{32{a[31]}}, a};
    b64 = {{32{b[31]}}, b};
    case (op)
      3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'b001: begin p = a64 * b64; return p[63:32]; end
      3'b010: begin p = a64 * $signed({32'b0, b}); return p[63:32]; end
      3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'b101: return (b == 32'h0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  // cycles from the start edge to done
  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2]) begin
      if (b == 32'h0) return 1;
      if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return 33;
    end
    return LAT_MUL;
  endfunction

  // model: one outstanding instruction, its age in cycles, and the last architectural result
  bit          busy = 1'b0;
  int          age = 0;
  int          exp_lat = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] last_res = '0;

  always @(negedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      last_res <= '0;
    end else if (busy) begin
      check("done", 32'(bus.done), 32'(age == exp_lat));
      check("stall", 32'(bus.stall), 32'(age < exp_lat));
      check("result", bus.result, (age == exp_lat) ? exp_res : last_res);
      if (age == exp_lat) last_res <= exp_res;
      if (bus.flush || age == exp_lat) busy <= 1'b0;
      else age <= age + 1;
    end else begin
      check("idle_done", 32'(bus.done), 32'h0);
      check("idle_stall", 32'(bus.stall), 32'(bus.start & ~bus.flush));
      check("idle_result", bus.result, last_res);
      if (bus.start && !bus.flush) begin
        busy    <= 1'b1;
        age     <= 1;
        exp_lat <= ref_lat(bus.op, bus.opa, bus.opb);
        exp_res <= ref_res(bus.op, bus.opa, bus.opb);
      end
    end
  end

  // hold start until done, scrambling operands after the start edge; returns at the done cycle's negedge
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    bus.start = 1'b1;
    bus.op    = o;
    bus.opa   = a;
    bus.opb   = b;
    lat       = 0;
    @(negedge clk);
    while (!bus.done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bus.opa = $urandom;
      bus.opb = $urandom;
      @(negedge clk);
    end
    if (!bus.done) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%0d actual_cycles=%0d expected=done", o, lat);
    end
    res = bus.result;
  endtask

  task automatic directed(input string nm, input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] want, input int want_lat);
    int          lat;
    logic [31:0] res;
    check({nm, "_model"}, ref_res(o, a, b), want);
    issue(o, a, b, lat, res);
    check({nm, "_result"}, res, want);
    check({nm, "_latency"}, 32'(lat), 32'(want_lat));
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    bus.start = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    int          lat;
    logic [31:0] res, a, b;
    logic [2:0]  o;
    int          sel;

    rst = 1'b1;
    bus.start = 1'b0;
    bus.op    = '0;
    bus.opa   = '0;
    bus.opb   = '0;
    bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_stall", 32'(bus.stall), 32'h0);
    check("reset_done", 32'(bus.done), 32'h0);
    check("reset_result", bus.result, 32'h0);
    rst = 1'b0;
    idle(1);

    directed("divu_100_7", 3'b101, 32'd100, 32'd7, 32'd14, 33);
    directed("remu_100_7", 3'b111, 32'd100, 32'd7, 32'd2, 33);
    idle(1);
    directed("div_m7_2", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    directed("rem_m7_2", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    directed("mulh_min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT_MUL);
    directed("mulhsu_m1_2", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, LAT_MUL);
    idle(2);
    directed("div_5_0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    directed("rem_5_0", 3'b110, 32'd5, 32'd0, 32'd5, 1);
    directed("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    directed("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
    idle(1);
    directed("mul_3_4", 3'b000, 32'd3, 32'd4, 32'd12, LAT_MUL);
    directed("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT_MUL);
    idle(2);

    // flush ten cycles into a DIVU, then flush and start together in IDLE
    bus.start = 1'b1; bus.op = 3'b101; bus.opa = 32'd1000; bus.opb = 32'd3;
    repeat (10) begin @(posedge clk); #1; end
    bus.flush = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    idle(2);
    directed("divu_9_3", 3'b101, 32'd9, 32'd3, 32'd3, 33);
    idle(1);

    // asynchronous reset between edges in the middle of RUN
    bus.start = 1'b1; bus.op = 3'b101; bus.opa = 32'd12345; bus.opb = 32'd7;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    bus.start = 1'b0;
    #1;
    check("async_rst_stall", 32'(bus.stall), 32'h0);
    check("async_rst_done", 32'(bus.done), 32'h0);
    check("async_rst_result", bus.result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    directed("mul_6_7", 3'b000, 32'd6, 32'd7, 32'd42, LAT_MUL);
    idle(1);

    // randomized ops with corner-biased operands, back-to-back or with gaps
    for (int i = 0; i < 120; i++) begin
      o   = 3'($urandom_range(0, 7));
      sel = $urandom_range(0, 9);
      a   = $urandom;
      b   = $urandom;
      if (sel == 0) b = 32'h0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) begin a = $urandom_range(0, 50); b = $urandom_range(1, 9); end
      else if (sel == 3) begin a = -($urandom_range(0, 50)); b = $urandom_range(1, 9); end
      bus.flush = 1'b0;
      issue(o, a, b, lat, res);
      @(posedge clk); #1;
      if ($urandom_range(0, 1) == 1) begin
        bus.start = 1'b0;
        bus.flush = ($urandom_range(0, 3) == 0);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
        bus.flush = 1'b0;
      end
    end

    idle(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the EX stage, directly upstream of the EX/MEM-WB segment register.
- It takes operands from the EX forwarding muxes and requests a pipeline stall while it computes.
- It presents a registered 32-bit result for the EX-stage AluOut mux to select in the cycle the stall releases.
- Handles MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU, including the RISC-V divide-by-zero and overflow rules.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- ITER_PER_CYCLE, 1, radix-2 steps per clock; legal values 1, 2, 4; sets the iteration count N = XLEN/ITER_PER_CYCLE.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  EX holds a valid M-extension instruction; level signal, held high for as long as EX is stalled.
- op  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- opa  in  32  rs1 value after forwarding.
- opb  in  32  rs2 value after forwarding.
- flush  in  1  EX flush (the clear of the EX segment register); aborts the operation in progress.
- stall  out  1  to the hazard unit; freezes IF/ID/EX and bubbles the EX/MEM-WB register.
- done  out  1  one-cycle pulse; result is valid in this cycle.
- result  out  32  registered result; holds its value until the next done.

Behaviour:
- FSM states: IDLE, RUN, DONE.
- Reset (asynchronous): state=IDLE, counter=0, result=0, done=0. Internal accumulators clear to 0.
- stall = (state==IDLE & start & ~flush) | (state==RUN). It is combinational so the first EX cycle is stalled.
- IDLE, start & ~flush at the clock edge:
  - Latch op.
  - Latch operand magnitudes and sign flags. Signedness per op: MULH/DIV/REM both signed; MULHSU opa signed, opb unsigned.
  - Load counter=N and go to RUN.
- Fast paths, taken from IDLE straight to DONE without entering RUN:
  - Divide by zero (opb==0): quotient=0xFFFFFFFF, remainder=opa.
  - Signed overflow (DIV/REM with opa=0x80000000, opb=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- RUN:
  - Multiply: shift-add of magnitudes into a 64-bit product.
  - Divide: restoring division of magnitudes, producing quotient and remainder.
  - Counter decrements each cycle. When counter reaches 1, go to DONE.
  - The signed fix-up is applied on that transition:
    - Product is negated when the operand signs differ.
    - Quotient is negated when the signs differ.
    - Remainder takes the sign of the dividend.
  - The selected word is written into result: MUL low 32 bits, MULH* high 32 bits, DIV* quotient, REM* remainder.
- DONE:
  - done=1 and stall=0, so the instruction advances with result.
  - start is ignored in DONE because it is the same instruction. Next edge goes to IDLE.
  - Back-to-back M instructions: the second one's start is accepted in the IDLE cycle that follows.
- Latency from the start edge to done: fast path 1 cycle; normal path N+1 cycles (33 at default).
- Operands are sampled only at the start edge. Changes to opa/opb during RUN have no effect.
- flush:
  - In any state, flush=1 at the edge forces IDLE with no done.
  - result keeps its previous value.
  - When flush and start arrive together in IDLE, flush wins.
- Arithmetic width: internal remainder is 33 bits for the trial subtract; product accumulator is 64 bits. All wrap is modulo 2^32 on the output.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiplies use a single combinational 33x33 signed multiplier. They go IDLE -> DONE with latency 1, and stall is high only in the start cycle.
- Not defined: multiplies use the iterative RUN path, with latency N+1 as above.
- Divides are identical in both builds.

Decomposition:
- Shared package muldiv_pkg holds:
  - funct3 op encoding constants.
  - FSM state encoding.
  - Special-case constants DIV_ZERO_Q=0xFFFFFFFF and INT_MIN=0x80000000.
  - Helper function is_div(op).
- One sub-module, mdu_step: combinational radix-2 step shared by the multiply and divide datapaths, instantiated ITER_PER_CYCLE times in a chain.

Test Plan:
- DIVU 100/7: start held high -> stall high for 33 cycles; done in cycle 33 with result=14. REMU on the same operands -> result=2.
- DIV -7/2 -> result=0xFFFFFFFD (-3). REM -7/2 -> result=0xFFFFFFFF (-1). MULH 0x80000000*0x80000000 -> result=0x40000000.
- DIV x/0 with x=5 -> done 1 cycle after start, result=0xFFFFFFFF. REM 5/0 -> result=5. DIV 0x80000000/-1 -> result=0x80000000. REM on the same operands -> result=0.
- Back-to-back MUL 3*4 then MULHU 0xFFFFFFFF*0xFFFFFFFF -> results 12 then 0xFFFFFFFE. The second start is accepted in the IDLE cycle after DONE; no double issue.
- flush asserted 10 cycles into DIVU -> state IDLE next cycle, no done, result unchanged. A new DIVU 9/3 then completes with result=3.
- rst asserted mid-RUN (asynchronously, between edges) -> stall, done and result read 0 immediately. With MULDIV_FAST_MUL_EN defined, MUL 6*7 -> done 1 cycle after start, result=42.
